// File: rtl/simple_fixed_pipe.sv
// Fixed-latency SIMD integer pipe: RR/RI10 halfword/word add, subtract and bitwise ops,
// with stall/flush control and per-stage forwarding taps. The RI10 immediate is imm[9:0].
module simple_fixed_pipe #(
  parameter int LATENCY = 3,
  parameter int VEC_W   = 128,
  parameter int ADDR_W  = 7
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [10:0]                         op,
  input  logic [2:0]                          format,
  input  logic [ADDR_W-1:0]                   rt_addr,
  input  logic [VEC_W-1:0]                    ra,
  input  logic [VEC_W-1:0]                    rb,
  input  logic [17:0]                         imm,
  input  logic                                reg_write,
  input  logic                                stall,
  input  logic                                flush,
  output logic [VEC_W-1:0]                    rt_wb,
  output logic [ADDR_W-1:0]                   rt_addr_wb,
  output logic                                reg_write_wb,
  output logic [LATENCY-2:0][VEC_W-1:0]       fwd_val,
  output logic [LATENCY-2:0][ADDR_W-1:0]      fwd_addr,
  output logic [LATENCY-2:0]                  fwd_we
);

  localparam int NWORD = VEC_W / 32;
  localparam int NHALF = VEC_W / 16;

  localparam logic [2:0]  FMT_RR   = 3'd0;
  localparam logic [2:0]  FMT_RI10 = 3'd2;

  localparam logic [10:0] OP_AH    = 11'b00011001000;
  localparam logic [10:0] OP_A     = 11'b00011000000;
  localparam logic [10:0] OP_SFH   = 11'b00001001000;
  localparam logic [10:0] OP_SF    = 11'b00001000000;
  localparam logic [10:0] OP_AND   = 11'b00011000001;
  localparam logic [10:0] OP_OR    = 11'b00001000001;
  localparam logic [10:0] OP_XOR   = 11'b01001000001;
  localparam logic [10:0] OP_NOR   = 11'b00001001001;
  localparam logic [7:0]  OP_AHI   = 8'b00011101;
  localparam logic [7:0]  OP_AI    = 8'b00011100;

  logic [VEC_W-1:0]                 result_s;
  logic                             legal_s;
  logic [15:0]                      imm_h_s;
  logic [31:0]                      imm_w_s;
  logic                             imm_unused_s;

  // Stage LATENCY-1 is the writeback register; the others are the forwarding taps.
  logic [LATENCY-1:0][VEC_W-1:0]    val_q, val_d;
  logic [LATENCY-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [LATENCY-1:0]               we_q, we_d;

  assign imm_h_s      = {{6{imm[9]}}, imm[9:0]};
  assign imm_w_s      = {{22{imm[9]}}, imm[9:0]};
  assign imm_unused_s = ^imm[17:10];

  // Lane-wise execute; anything not decoded (including nop) is flagged illegal.
  always_comb begin
    result_s = '0;
    legal_s  = 1'b0;
    if (format == FMT_RR) begin
      legal_s = 1'b1;
      case (op)
        OP_AH: begin
          for (int h = 0; h < NHALF; h++)
            result_s[16*h +: 16] = ra[16*h +: 16] + rb[16*h +: 16];
        end
        OP_A: begin
          for (int w = 0; w < NWORD; w++)
            result_s[32*w +: 32] = ra[32*w +: 32] + rb[32*w +: 32];
        end
        OP_SFH: begin
          for (int h = 0; h < NHALF; h++)
            result_s[16*h +: 16] = rb[16*h +: 16] - ra[16*h +: 16];
        end
        OP_SF: begin
          for (int w = 0; w < NWORD; w++)
            result_s[32*w +: 32] = rb[32*w +: 32] - ra[32*w +: 32];
        end
        OP_AND:  result_s = ra & rb;
        OP_OR:   result_s = ra | rb;
        OP_XOR:  result_s = ra ^ rb;
        OP_NOR:  result_s = ~(ra | rb);
        default: legal_s  = 1'b0;
      endcase
    end else if (format == FMT_RI10) begin
      legal_s = 1'b1;
      case (op[10:3])
        OP_AHI: begin
          for (int h = 0; h < NHALF; h++)
            result_s[16*h +: 16] = ra[16*h +: 16] + imm_h_s;
        end
        OP_AI: begin
          for (int w = 0; w < NWORD; w++)
            result_s[32*w +: 32] = ra[32*w +: 32] + imm_w_s;
        end
        default: legal_s = 1'b0;
      endcase
    end else begin
      legal_s = 1'b0;
    end
  end

  // Stage advance: flush beats stall; illegal issues enter as all-zero bubbles.
  always_comb begin
    val_d  = val_q;
    addr_d = addr_q;
    we_d   = we_q;
    if (flush) begin
      val_d  = '0;
      addr_d = '0;
      we_d   = '0;
    end else if (stall) begin
      val_d  = val_q;
      addr_d = addr_q;
      we_d   = we_q;
    end else begin
      val_d[0]  = legal_s ? result_s : '0;
      addr_d[0] = legal_s ? rt_addr : '0;
      we_d[0]   = legal_s & reg_write;
      for (int s = 1; s < LATENCY; s++) begin
        val_d[s]  = val_q[s-1];
        addr_d[s] = addr_q[s-1];
        we_d[s]   = we_q[s-1];
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      addr_q <= '0;
      we_q   <= '0;
    end else begin
      val_q  <= val_d;
      addr_q <= addr_d;
      we_q   <= we_d;
    end
  end

  assign rt_wb        = val_q[LATENCY-1];
  assign rt_addr_wb   = addr_q[LATENCY-1];
  assign reg_write_wb = we_q[LATENCY-1];
  assign fwd_val      = val_q[LATENCY-2:0];
  assign fwd_addr     = addr_q[LATENCY-2:0];
  assign fwd_we       = we_q[LATENCY-2:0];

endmodule

// File: tb/tb_simple_fixed_pipe.sv
// Directed bench for simple_fixed_pipe: scoreboard of expected writebacks keyed by due cycle,
// plus forwarding, stall, flush and reset checks.
module tb_simple_fixed_pipe;
  localparam int LATENCY = 3;
  localparam int VEC_W   = 128;
  localparam int ADDR_W  = 7;

  localparam logic [10:0] OP_AH  = 11'b00011001000;
  localparam logic [10:0] OP_A   = 11'b00011000000;
  localparam logic [10:0] OP_SFH = 11'b00001001000;
  localparam logic [10:0] OP_SF  = 11'b00001000000;
  localparam logic [10:0] OP_AND = 11'b00011000001;
  localparam logic [10:0] OP_OR  = 11'b00001000001;
  localparam logic [10:0] OP_XOR = 11'b01001000001;
  localparam logic [10:0] OP_NOR = 11'b00001001001;
  localparam logic [10:0] OP_AHI = 11'b00011101000;
  localparam logic [10:0] OP_AI  = 11'b00011100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           reset, reg_write, stall, flush;
  logic [10:0]                    op;
  logic [2:0]                     format;
  logic [ADDR_W-1:0]              rt_addr;
  logic [VEC_W-1:0]               ra, rb;
  logic [17:0]                    imm;
  logic [VEC_W-1:0]               rt_wb;
  logic [ADDR_W-1:0]              rt_addr_wb;
  logic                           reg_write_wb;
  logic [LATENCY-2:0][VEC_W-1:0]  fwd_val;
  logic [LATENCY-2:0][ADDR_W-1:0] fwd_addr;
  logic [LATENCY-2:0]             fwd_we;

  simple_fixed_pipe #(.LATENCY(LATENCY), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .stall(stall), .flush(flush),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .fwd_val(fwd_val), .fwd_addr(fwd_addr), .fwd_we(fwd_we)
  );

  typedef struct {
    logic [VEC_W-1:0]  val;
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;

  exp_t                           sb[$];
  int                             checks = 0;
  int                             errors = 0;
  int                             cyc = 0;
  logic [VEC_W-1:0]               last_val;
  logic [VEC_W-1:0]               s_wb;
  logic [ADDR_W-1:0]              s_addr_wb;
  logic                           s_we_wb;
  logic [LATENCY-2:0][VEC_W-1:0]  s_fval;
  logic [LATENCY-2:0][ADDR_W-1:0] s_faddr;
  logic [LATENCY-2:0]             s_fwe;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: walks 32-bit words and splits halfwords explicitly.
  function automatic logic ref_alu(input logic [10:0] o, input logic [2:0] f,
                                   input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                   input logic [17:0] im, output logic [VEC_W-1:0] r);
    logic [31:0] x, y, z, iw;
    logic [15:0] ih;
    logic        ok;
    ih = {{6{im[9]}}, im[9:0]};
    iw = {{22{im[9]}}, im[9:0]};
    r  = '0;
    ok = 1'b1;
    for (int w = 0; w < VEC_W/32; w++) begin
      x = a[32*w +: 32];
      y = b[32*w +: 32];
      z = 32'h0;
      if (f == 3'd0) begin
        case (o)
          OP_AH:   z = {x[31:16] + y[31:16], x[15:0] + y[15:0]};
          OP_A:    z = x + y;
          OP_SFH:  z = {y[31:16] - x[31:16], y[15:0] - x[15:0]};
          OP_SF:   z = y - x;
          OP_AND:  z = x & y;
          OP_OR:   z = x | y;
          OP_XOR:  z = x ^ y;
          OP_NOR:  z = ~(x | y);
          default: ok = 1'b0;
        endcase
      end else if (f == 3'd2) begin
        case (o[10:3])
          8'b00011101: z = {x[31:16] + ih, x[15:0] + ih};
          8'b00011100: z = x + iw;
          default:     ok = 1'b0;
        endcase
      end else begin
        ok = 1'b0;
      end
      r[32*w +: 32] = z;
    end
    if (!ok) r = '0;
    return ok;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("wb_we", reg_write_wb, 1'b1);
      chk("wb_val", rt_wb, sb[0].val);
      chk("wb_addr", rt_addr_wb, sb[0].addr);
      void'(sb.pop_front());
    end else begin
      chk("wb_idle", reg_write_wb, 1'b0);
    end
  endtask

  task automatic idle_inputs();
    op = '0; format = '0; rt_addr = '0; ra = '0; rb = '0; imm = '0; reg_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [10:0] o, input logic [2:0] f, input logic [ADDR_W-1:0] ad,
                       input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                       input logic [17:0] im, input logic we,
                       input logic use_exp, input logic [VEC_W-1:0] exp_val);
    logic [VEC_W-1:0] r;
    logic             ok;
    exp_t             e;
    ok = ref_alu(o, f, a, b, im, r);
    if (use_exp) r = exp_val;
    op = o; format = f; rt_addr = ad; ra = a; rb = b; imm = im; reg_write = we;
    if (ok && we) begin
      e.val = r; e.addr = ad; e.due = cyc + LATENCY;
      sb.push_back(e);
    end
    last_val = r;
    tick();
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rt_wb"}, rt_wb, '0);
    chk({tag, "_addr_wb"}, rt_addr_wb, '0);
    chk({tag, "_we_wb"}, reg_write_wb, '0);
    chk({tag, "_fwd_val"}, fwd_val, '0);
    chk({tag, "_fwd_addr"}, fwd_addr, '0);
    chk({tag, "_fwd_we"}, fwd_we, '0);
  endtask

  function automatic logic [VEC_W-1:0] rnd_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; last_val = '0;
    idle_inputs();
    idle(2);
    chk_all_zero("reset");
    reset = 1'b0;

    // First edge out of reset: ah saturating-looking halfwords wrap to 0x8000.
    issue(OP_AH, 3'd0, 7'd5, {8{16'h7FFF}}, {8{16'h0001}}, 18'h0, 1'b1, 1'b1, {8{16'h8000}});
    idle(3);
    issue(OP_AI, 3'd2, 7'd6, {4{32'hFFFFFFFF}}, '0, 18'h003FF, 1'b1, 1'b1, {4{32'hFFFFFFFE}});
    issue(OP_AHI | 11'h5, 3'd2, 7'd8, {8{16'hFFFF}}, '0, 18'h00001, 1'b1, 1'b1, '0);
    idle(3);

    // Back-to-back a, sf, xor with forwarding taps.
    issue(OP_A, 3'd0, 7'd1, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk("fwd_addr0_a", fwd_addr[0], 7'd1);
    chk("fwd_we0_a", fwd_we[0], 1'b1);
    chk("fwd_val0_a", fwd_val[0], last_val);
    issue(OP_SF, 3'd0, 7'd2, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk("fwd_addr0_sf", fwd_addr[0], 7'd2);
    chk("fwd_addr1_sf", fwd_addr[1], 7'd1);
    issue(OP_XOR, 3'd0, 7'd3, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk("fwd_addr0_xor", fwd_addr[0], 7'd3);
    chk("fwd_addr1_xor", fwd_addr[1], 7'd2);
    idle(3);

    // Remaining ops on random operands.
    issue(OP_SFH, 3'd0, 7'd20, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    issue(OP_AND, 3'd0, 7'd21, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    issue(OP_NOR, 3'd0, 7'd22, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    issue(OP_AHI, 3'd2, 7'd23, rnd_vec(), '0, 18'h00200, 1'b1, 1'b0, '0);
    issue(OP_OR, 3'd0, 7'd11, rnd_vec(), rnd_vec(), 18'h0, 1'b0, 1'b0, '0);
    chk("nowe_fwd_we", fwd_we[0], 1'b0);
    chk("nowe_fwd_val", fwd_val[0], last_val);
    chk("nowe_fwd_addr", fwd_addr[0], 7'd11);
    issue(OP_AH, 3'd1, 7'd12, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk("badfmt_fwd", {fwd_val[0], fwd_addr[0], fwd_we[0]}, '0);
    issue(11'h7FF, 3'd2, 7'd13, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk("badri_fwd", {fwd_val[0], fwd_addr[0], fwd_we[0]}, '0);
    idle(3);

    // Stall for two cycles with junk on the inputs.
    issue(OP_AH, 3'd0, 7'd9, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    s_wb = rt_wb; s_addr_wb = rt_addr_wb; s_we_wb = reg_write_wb;
    s_fval = fwd_val; s_faddr = fwd_addr; s_fwe = fwd_we;
    stall = 1'b1;
    op = OP_A; format = 3'd0; rt_addr = 7'd7; ra = rnd_vec(); rb = rnd_vec(); reg_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      foreach (sb[k]) sb[k].due++;
      tick();
      chk("stall_rt_wb", rt_wb, s_wb);
      chk("stall_addr_wb", rt_addr_wb, s_addr_wb);
      chk("stall_we_wb", reg_write_wb, s_we_wb);
      chk("stall_fwd", {s_fval, s_faddr, s_fwe}, {fwd_val, fwd_addr, fwd_we});
    end
    stall = 1'b0;
    idle_inputs();
    idle(3);

    // Flush (with stall also high) kills two in-flight ops and the one presented.
    issue(OP_A, 3'd0, 7'd30, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    issue(OP_SF, 3'd0, 7'd31, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    flush = 1'b1; stall = 1'b1;
    op = OP_XOR; format = 3'd0; rt_addr = 7'd4; ra = rnd_vec(); rb = rnd_vec(); reg_write = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0; stall = 1'b0;
    idle_inputs();
    chk_all_zero("flush");
    for (int i = 0; i < LATENCY; i++) begin
      tick();
      chk("flush_fwd_we", fwd_we, '0);
    end

    // Reset with a full pipeline, then nop and an undefined opcode.
    issue(OP_A, 3'd0, 7'd40, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    issue(OP_AH, 3'd0, 7'd41, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    reset = 1'b1; flush = 1'b1; stall = 1'b1;
    op = OP_AND; format = 3'd0; rt_addr = 7'd42; ra = rnd_vec(); rb = rnd_vec(); reg_write = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    idle_inputs();
    chk_all_zero("rst_full");
    issue(11'h000, 3'd0, 7'd6, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk_all_zero("rst_nop");
    issue(11'h7FF, 3'd0, 7'd6, rnd_vec(), rnd_vec(), 18'h0, 1'b1, 1'b0, '0);
    chk_all_zero("rst_undef");
    for (int i = 0; i < LATENCY; i++) begin
      tick();
      chk_all_zero("rst_drain");
    end
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
